// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment patterns (a..g, active low) and helpers.
package seg7_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Indexed by nibble; bit 0 is segment a.
  localparam seg_t SEG_PATTERNS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder with forced blanking.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg_t       seg_c
);

  always_comb begin
    seg_c = SEG_PATTERNS[nibble];
    if (blank) seg_c = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed NUM_DIGITS seven-segment scanner with leading-zero blanking and inter-digit gap.
// Optional decimal points compiled in with SEG7_DP_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  localparam int unsigned IDX_W      = idx_width(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic [0:6]              leds,
  output logic [NUM_DIGITS-1:0]   adrive,
  output logic [IDX_W-1:0]        digit_idx
`ifdef SEG7_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic                    dp_n
`endif
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  tc;
  logic [IDX_W-1:0]      idx_nxt;
  logic [VAL_W-1:0]      shadow;
  logic [NUM_DIGITS-1:0] zero_above;
  logic [NUM_DIGITS-1:0] adrive_nxt;
  logic [3:0]            nibble;
  logic                  blank;
  seg_t                  seg_c;

  // Prescaler, digit stepping and anode selection (count 0 is the gap cycle).
  always_comb begin
    tc         = (cnt == CNT_W'(REFRESH_DIV - 1));
    cnt_nxt    = tc ? '0 : cnt + CNT_W'(1);
    idx_nxt    = digit_idx;
    adrive_nxt = '1;
    if (tc) begin
      idx_nxt = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end
    if (cnt != '0) adrive_nxt[digit_idx] = 1'b0;
  end

  // zero_above[k]: nibble k and every higher nibble are zero.
  always_comb begin
    zero_above = '0;
    zero_above[NUM_DIGITS-1] = (shadow[VAL_W-1 -: 4] == 4'h0);
    for (int k = int'(NUM_DIGITS) - 2; k >= 0; k--) begin
      zero_above[k] = zero_above[k+1] && (shadow[4*k +: 4] == 4'h0);
    end
  end

  always_comb begin
    nibble = shadow[4*int'(digit_idx) +: 4];
    blank  = lz_blank && (digit_idx != '0) && zero_above[digit_idx];
  end

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .blank  (blank),
    .seg_c  (seg_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      digit_idx <= '0;
      shadow    <= '0;
      leds      <= SEG_BLANK;
      adrive    <= '1;
    end else begin
      cnt       <= cnt_nxt;
      digit_idx <= idx_nxt;
      leds      <= seg_c;
      adrive    <= adrive_nxt;
      if (load) shadow <= value;
    end
  end

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0] dp_shadow;
  logic                  dp_n_nxt;

  // Decimal point ignores leading-zero blanking but honours the gap cycle.
  always_comb begin
    dp_n_nxt = 1'b1;
    if (cnt != '0) dp_n_nxt = ~dp_shadow[digit_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_shadow <= '0;
      dp_n      <= 1'b1;
    end else begin
      dp_n <= dp_n_nxt;
      if (load) dp_shadow <= dp;
    end
  end
`endif

endmodule
